m_led_arbiter: RTL

//  Round-robin scheduler that shares the 4-LED bank between 4 requesters.
//  A built-in prescaler generates a periodic tick. Each grant holds the LEDs for SLOT_TICKS ticks.
//  It sits between the pattern sources (blinkers, status logic) and the board LEDs.
//  It replaces a single hard-wired blinker driving w_led directly.

---
 rtl/m_led_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/m_led_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : m_led_arbiter
// Purpose  : Round-robin scheduler sharing a 4-LED bank between 4 requesters.
//            A free-running prescaler produces a periodic tick. Each grant
//            owns the LEDs for SLOT_TICKS ticks, or less if its requester
//            releases early. When no grant is held, IDLE_PAT is driven.
// Ports    : w_clk   in   1   system clock, all state on posedge
//            w_rst   in   1   synchronous reset, active-high
//            w_req   in   4   level-sensitive requests, bit i = requester i
//            w_pat   in   16  LED patterns, requester i at [4i+3:4i]
//            w_grant out  4   registered one-hot grant, 0 when idle
//            w_busy  out  1   high while a grant is held
//            w_tick  out  1   one-cycle prescaler pulse
//            w_led   out  4   registered LED drive
// Revision : 1.0  initial release
// ============================================================================
module m_led_arbiter #(
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned SLOT_TICKS = 4,
    parameter logic [3:0]  IDLE_PAT   = 4'b0000
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic [3:0]  w_req,
    input  logic [15:0] w_pat,
    output logic [3:0]  w_grant,
    output logic        w_busy,
    output logic        w_tick,
    output logic [3:0]  w_led
);

    localparam int unsigned c_slot_w = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam logic [31:0]         c_cnt_last  = 32'(TICK_DIV - 1);
    localparam logic [c_slot_w-1:0] c_slot_last = (c_slot_w)'(SLOT_TICKS - 1);
    localparam logic [c_slot_w-1:0] c_slot_one  = (c_slot_w)'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_cnt;
    logic [3:0]          r_grant;
    logic [3:0]          w_grant_nxt;
    logic [1:0]          r_ptr;
    logic [1:0]          w_ptr_nxt;
    logic [c_slot_w-1:0] r_slot;
    logic [c_slot_w-1:0] w_slot_nxt;
    logic [3:0]          r_led;
    logic [3:0]          w_led_sel;
    logic [1:0]          w_grant_idx;
    logic [1:0]          w_ptr_adv;
    logic [1:0]          w_arb_ptr;
    logic [3:0]          w_elig;
    logic [3:0]          w_winner;
    logic                w_release;
    logic                w_expire;

    // Search req starting at ptr, wrapping mod 4; returns one-hot winner or 0.
    // Iterating from the farthest offset down lets the nearest one win.
    function automatic logic [3:0] f_rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [3:0] pick;
        logic [1:0] idx;
        pick = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                pick = 4'b0001 << idx;
            end
        end
        return pick;
    endfunction

    function automatic logic [1:0] f_onehot_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // Prescaler: free-running, independent of the arbiter state.
    // ------------------------------------------------------------------
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_cnt <= 32'd0;
        end else if (r_cnt == c_cnt_last) begin
            r_cnt <= 32'd0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // Gated by reset so the pulse never shows while reset is asserted.
    assign w_tick = !w_rst && (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------
    // Slot-end detection and re-arbitration
    // ------------------------------------------------------------------
    assign w_grant_idx = f_onehot_idx(r_grant);
    assign w_ptr_adv   = w_grant_idx + 2'd1;
    // A dropped request ends the slot at once; this also covers the case
    // where release and expiry coincide, so the pointer advances only once.
    assign w_release   = (r_state == ST_GRANT) && ((w_req & r_grant) == 4'b0000);
    assign w_expire    = (r_state == ST_GRANT) && w_tick && (r_slot == c_slot_last);
    // The outgoing requester stays eligible on plain expiry, not on release.
    assign w_elig      = w_release ? (w_req & ~r_grant) : w_req;
    assign w_arb_ptr   = (r_state == ST_IDLE) ? r_ptr : w_ptr_adv;
    assign w_winner    = f_rr_pick(w_elig, w_arb_ptr);

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state <= ST_IDLE;
            r_grant <= 4'b0000;
            r_ptr   <= 2'd0;
            r_slot  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_slot  <= w_slot_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_slot_nxt  = r_slot;
        case (r_state)
            ST_IDLE: begin
                if (w_req != 4'b0000) begin
                    w_grant_nxt = w_winner;
                    w_slot_nxt  = '0;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_release || w_expire) begin
                    w_ptr_nxt = w_ptr_adv;
                    if (w_winner != 4'b0000) begin
                        w_grant_nxt = w_winner;
                        w_slot_nxt  = '0;
                    end else begin
                        w_grant_nxt = 4'b0000;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_tick) begin
                    w_slot_nxt = r_slot + c_slot_one;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 4'b0000;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // LED output: pattern of the currently held grant, one cycle later.
    // ------------------------------------------------------------------
    always_comb begin
        w_led_sel = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (r_grant[i]) begin
                w_led_sel = w_led_sel | w_pat[4*i +: 4];
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_led <= IDLE_PAT;
        end else begin
            r_led <= (r_state == ST_GRANT) ? w_led_sel : IDLE_PAT;
        end
    end

    assign w_grant = r_grant;
    assign w_busy  = (r_state == ST_GRANT);
    assign w_led   = r_led;

endmodule
`default_nettype wire
